// File: rtl/result_pkg.sv
// Shared definitions for the result slot writer and reader: the reader FSM
// state encoding and the default slot geometry both sides must agree on.
package result_pkg;

    // Default number of rotating result slots.
    localparam int RESULT_NUM_SLOTS = 5;

    // Default address of slot 0 in result memory.
    localparam logic [31:0] RESULT_BASE_ADDR = 32'h0000_0000;

    // Default address step between consecutive slots.
    localparam logic [31:0] RESULT_SLOT_STRIDE = 32'h0000_0004;

    // Reader FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } rd_state_t;

endpackage : result_pkg

// File: rtl/result_read_fsm_slot_ptr_counter.sv
// Rotating slot pointer. It steps by one on advance and wraps from
// NUM_SLOTS-1 back to 0. The slot writer uses the same block for its
// pointer, so both sides walk the slots in the same order.
module slot_ptr_counter #(
    parameter int NUM_SLOTS = 5,
    parameter int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    // Pointer register: on advance, step to the next slot and wrap after the last one.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST_SLOT) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule : slot_ptr_counter

// File: rtl/result_read_fsm.sv
// Reads result slots in write order and hands each result to the host over a
// valid/ready handshake. Each slot committed by the writer adds one unread
// result. The FSM fetches the slot at rd_ptr from result memory. Memory returns
// data one cycle after the read strobe. The FSM then holds that word on
// rd_data until the host takes it.
//
// Optional build macro: RESULT_READ_DROP_CNT_EN adds the drop_cnt output. It is
// a saturating count of commits lost because every slot was still unread.
module result_read_fsm
    import result_pkg::*;
#(
    parameter int              NUM_SLOTS   = RESULT_NUM_SLOTS,
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(RESULT_BASE_ADDR),
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = ADDR_W'(RESULT_SLOT_STRIDE)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_commit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
`ifdef RESULT_READ_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             pop;
    logic             overflow_evt;

    // The host takes the presented result in this cycle.
    assign pop = rd_valid && rd_ready;

    // The slot address follows the read pointer directly, so it is valid in ISSUE.
    assign mem_addr = BASE_ADDR + ADDR_W'(rd_ptr) * SLOT_STRIDE;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // The read pointer moves only when a result is consumed, so a slot being
    // fetched or presented keeps its address.
    slot_ptr_counter #(
        .NUM_SLOTS (NUM_SLOTS),
        .PTR_W     (PTR_W)
    ) u_rd_ptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .advance (pop),
        .ptr     (rd_ptr)
    );

    // Unread-slot bookkeeping. A commit and a pop in the same cycle cancel out.
    // A commit while full with no pop is lost and raises an overflow event.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_nxt    = count;
        overflow_evt = 1'b0;
        unique case ({wr_commit, pop})
            2'b10: begin
                if (count == CNT_FULL) begin
                    overflow_evt = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Register the unread-slot count and the sticky overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (overflow_evt) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and read strobe. A pop in PRESENT goes back to ISSUE if a
    // result is still unread, counting a commit that arrives in the same cycle.
    always_comb begin
        state_nxt = state;
        mem_ren   = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_ren   = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (pop) begin
                    state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Presentation register. It loads the memory word one cycle after the
    // strobe and holds it until the host takes it.
    // NOTE: rd_data is a single register, not a memory array, so it gets an explicit reset value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (state == CAPTURE) begin
            rd_data  <= mem_rdata;
            rd_valid <= 1'b1;
        end else if (pop) begin
            rd_valid <= 1'b0;
        end
    end

`ifdef RESULT_READ_DROP_CNT_EN
    // Count lost commits and hold the count at its maximum value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_cnt <= 8'h00;
        end else if (overflow_evt && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule : result_read_fsm

// File: tb/tb_result_read_fsm.sv
// Directed bench for result_read_fsm. The memory model returns
// 32'hCAFE_0001 + address, one cycle after each read strobe. Inputs change
// 1 ns after the rising edge. A monitor samples on the falling edge.
// Build with RESULT_READ_DROP_CNT_EN defined to cover drop_cnt as well.
module tb_result_read_fsm;

    logic        clk;
    logic        n_rst;
    logic        wr_commit;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        empty;
    logic        full;
    logic        overflow;
`ifdef RESULT_READ_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_checks;
    int n_errors;

    logic        mon_en;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];

    result_read_fsm dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_commit (wr_commit),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
`ifdef RESULT_READ_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory: data is valid exactly one cycle after mem_ren, and holds garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? (32'hCAFE_0001 + mem_addr) : 32'hDEAD_BEEF;
    end

    // Log every read strobe address and every accepted result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_ren) addr_q.push_back(mem_addr);
            if (rd_valid && rd_ready) data_q.push_back(rd_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        wr_commit = 1'b0;
        rd_ready  = 1'b0;
        mon_en    = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        addr_q.delete();
        data_q.delete();
        tick();
    endtask

    task automatic commits(input int n);
        for (int i = 0; i < n; i++) begin
            wr_commit = 1'b1;
            tick();
        end
        wr_commit = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !rd_valid; i++) tick();
        check(tag, 32'(rd_valid), 32'd1);
    endtask

    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        wr_commit = 1'b0;
        rd_ready  = 1'b0;
        n_rst     = 1'b1;
        exp_addr  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_data  = '{32'hCAFE_0001, 32'hCAFE_0005, 32'hCAFE_0009, 32'hCAFE_000D, 32'hCAFE_0011};

        // 1: reset and idle
        do_reset();
        repeat (10) tick();
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_full", 32'(full), 32'd0);
        check("idle_valid", 32'(rd_valid), 32'd0);
        check("idle_ren", 32'(mem_ren), 32'd0);
        check("idle_addr", mem_addr, 32'h0);
        check("idle_ovf", 32'(overflow), 32'd0);
        check("idle_data", rd_data, 32'h0);
`ifdef RESULT_READ_DROP_CNT_EN
        check("idle_drop", 32'(drop_cnt), 32'd0);
`endif

        // 2: single commit, three-cycle latency, then pop
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("s2_c1_empty", 32'(empty), 32'd0);
        check("s2_c1_valid", 32'(rd_valid), 32'd0);
        tick();
        check("s2_c2_ren", 32'(mem_ren), 32'd1);
        check("s2_c2_addr", mem_addr, 32'h0);
        tick();
        check("s2_c3_ren", 32'(mem_ren), 32'd0);
        check("s2_c3_valid", 32'(rd_valid), 32'd0);
        tick();
        check("s2_c4_valid", 32'(rd_valid), 32'd1);
        check("s2_c4_data", rd_data, 32'hCAFE_0001);
        tick();
        check("s2_hold_valid", 32'(rd_valid), 32'd1);
        check("s2_hold_data", rd_data, 32'hCAFE_0001);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("s2_pop_valid", 32'(rd_valid), 32'd0);
        check("s2_pop_empty", 32'(empty), 32'd1);
        check("s2_pop_addr", mem_addr, 32'h4);

        // 3: five commits, drained in order with wrap
        do_reset();
        mon_en = 1'b1;
        commits(5);
        check("s3_full", 32'(full), 32'd1);
        rd_ready = 1'b1;
        repeat (25) tick();
        rd_ready = 1'b0;
        check("s3_nreads", 32'(addr_q.size()), 32'd5);
        check("s3_npops", 32'(data_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < addr_q.size()) check($sformatf("s3_addr%0d", i), addr_q[i], exp_addr[i]);
            if (i < data_q.size()) check($sformatf("s3_data%0d", i), data_q[i], exp_data[i]);
        end
        check("s3_empty", 32'(empty), 32'd1);
        check("s3_full_end", 32'(full), 32'd0);
        check("s3_wrap_addr", mem_addr, 32'h0);

        // 4: overflow on sixth commit while full
        do_reset();
        commits(5);
        check("s4_full5", 32'(full), 32'd1);
        check("s4_ovf5", 32'(overflow), 32'd0);
        commits(1);
        check("s4_ovf6", 32'(overflow), 32'd1);
        check("s4_full6", 32'(full), 32'd1);
`ifdef RESULT_READ_DROP_CNT_EN
        check("s4_drop", 32'(drop_cnt), 32'd1);
`endif
        mon_en   = 1'b1;
        rd_ready = 1'b1;
        repeat (25) tick();
        rd_ready = 1'b0;
        check("s4_npops", 32'(data_q.size()), 32'd5);
        check("s4_ovf_sticky", 32'(overflow), 32'd1);
        check("s4_empty", 32'(empty), 32'd1);

        // 5: commit coincident with pop at count=2
        do_reset();
        commits(2);
        wait_valid("s5_wait_valid", 10);
        check("s5_first", rd_data, 32'hCAFE_0001);
        rd_ready  = 1'b1;
        wr_commit = 1'b1;
        tick();
        rd_ready  = 1'b0;
        wr_commit = 1'b0;
        check("s5_valid_drop", 32'(rd_valid), 32'd0);
        check("s5_issue_now", 32'(mem_ren), 32'd1);
        check("s5_issue_addr", mem_addr, 32'h4);
        check("s5_not_empty", 32'(empty), 32'd0);
        mon_en   = 1'b1;
        rd_ready = 1'b1;
        repeat (15) tick();
        rd_ready = 1'b0;
        check("s5_npops", 32'(data_q.size()), 32'd2);
        if (data_q.size() > 0) check("s5_data0", data_q[0], 32'hCAFE_0005);
        if (data_q.size() > 1) check("s5_data1", data_q[1], 32'hCAFE_0009);
        check("s5_empty", 32'(empty), 32'd1);

        // 6: asynchronous reset while presenting
        do_reset();
        commits(1);
        wait_valid("s6_wait_valid", 10);
        n_rst = 1'b0;
        #1;
        check("s6_valid_async", 32'(rd_valid), 32'd0);
        check("s6_empty", 32'(empty), 32'd1);
        check("s6_addr", mem_addr, 32'h0);
        tick();
        n_rst    = 1'b1;
        mon_en   = 1'b1;
        rd_ready = 1'b1;
        repeat (10) tick();
        rd_ready = 1'b0;
        check("s6_no_stale", 32'(data_q.size()), 32'd0);
        check("s6_no_read", 32'(addr_q.size()), 32'd0);
        check("s6_valid_end", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_result_read_fsm
